uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- CPU-side partner of the host boot protocol; sits between the CPU's UART_RX/UART_TX byte interfaces and the instruction memory and stdin path.
- Announces itself with 0x99, receives a 4-byte program size and then the program bytes, and packs them into 32-bit words for instruction memory.
- Sends 0xAA when loading is complete, then buffers incoming stdin bytes in a FIFO that the CPU pops.

Parameters:
- IMEM_ADDR_W, 14: instruction memory word-address width; capacity is 4*2^IMEM_ADDR_W bytes.
- FIFO_DEPTH, 16: stdin FIFO entries; must be a power of two and at least 2.
- SYNC_BYTE, 8'h99: boot request byte.
- READY_BYTE, 8'hAA: load-complete byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_rdata  in  8  received byte from UART_RX
- rx_rdata_ready  in  1  one-cycle pulse; rx_rdata is valid in that cycle
- rx_ferr  in  1  framing error flag, qualified by rx_rdata_ready
- tx_sdata  out  8  byte to UART_TX
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART_TX busy
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  IMEM_ADDR_W  word address
- imem_wdata  out  32  word data
- boot_done  out  1  high once RUN is reached; releases the CPU core
- stdin_rdata  out  8  head of the stdin FIFO (first-word fall-through)
- stdin_valid  out  1  FIFO not empty
- stdin_pop  in  1  consume the head; ignored when stdin_valid is low
- err  out  1  sticky error flag

Behaviour:
- Reset values (asynchronous, all outputs low or zero):
  - tx_start=0, tx_sdata=0, imem_we=0, imem_addr=0, imem_wdata=0
  - boot_done=0, stdin_valid=0, err=0
  - FIFO empty, state=SEND_SYNC
- States: SEND_SYNC -> RECV_SIZE -> RECV_PROG -> SEND_READY -> RUN. RUN is terminal until reset.
- TX rule:
  - tx_start pulses for exactly one cycle, only when tx_busy=0 and the tx guard flag is clear.
  - tx_sdata is driven in the same cycle as tx_start and held until the next send.
  - The guard flag is set with the pulse and cleared the following cycle. This masks UART_TX's one-cycle-late tx_busy.
- SEND_SYNC: send SYNC_BYTE once; move to RECV_SIZE in the cycle after the pulse. RX bytes arriving in SEND_SYNC are discarded.
- RECV_SIZE:
  - Collect 4 bytes, little-endian, into a 32-bit byte count.
  - If the size is 0, go to SEND_READY.
  - If the size exceeds 4*2^IMEM_ADDR_W, set err and still consume all size bytes; bytes beyond capacity produce no write.
- RECV_PROG:
  - Bytes are packed little-endian: the first byte goes to bits [7:0].
  - On the 4th byte of a word, imem_we pulses one cycle, in the cycle after that byte's rx_rdata_ready, with imem_addr = word index (starting at 0).
  - Byte counter is 32 bits; the state ends when count equals size.
  - If size mod 4 != 0, the final partial word is written zero-padded in the upper bytes, one cycle after its last byte.
  - Then go to SEND_READY.
- SEND_READY: send READY_BYTE. boot_done rises and the state becomes RUN in the cycle after the tx_start pulse.
- RUN: every accepted rx byte is pushed into the FIFO.
  - FIFO full and no pop in the same cycle: byte is dropped, err set.
  - Simultaneous push and pop when full: both succeed, occupancy unchanged.
  - Simultaneous push and pop when empty: the byte is pushed. stdin_valid rises the next cycle.
  - Push-to-stdin_valid latency is 1 cycle.
- rx_ferr with rx_rdata_ready, in any state: the byte is discarded (not counted, not pushed) and err is set.
- Reset mid-operation aborts immediately. After release, the block restarts from SEND_SYNC and sends 0x99 again.

Test Plan:
- Release reset with tx_busy=0 -> tx_start one-cycle pulse with tx_sdata=0x99 within 2 cycles. No second pulse while a model holds tx_busy for 10 cycles.
- After 0x99, send size bytes 08 00 00 00, then 11 22 33 44 55 66 77 88 -> imem writes (addr 0, 0x44332211) then (addr 1, 0x88776655). Then tx_sdata=0xAA pulse and boot_done=1 the cycle after.
- Size 06 00 00 00, bytes 01..06 -> writes (0, 0x04030201) and (1, 0x00000605).
- Size 00 00 00 00 -> no imem_we, 0xAA sent directly. Size 0x00100000 with IMEM_ADDR_W=4 -> err=1, no write with addr beyond 15.
- In RUN with FIFO_DEPTH=16 and no pops, send 17 bytes 0x00..0x10 -> err=1, stdin_rdata=0x00. Popping 16 times returns 0x00..0x0F, then stdin_valid=0.
- Assert reset_n=0 after 3 program bytes, then release -> all outputs return to reset values, and 0x99 is re-sent with a fresh imem_addr starting at 0. A byte with rx_ferr=1 during RECV_SIZE sets err and is not counted.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Boot-side UART loader: announces with SYNC_BYTE, receives size + program into imem words,
// sends READY_BYTE, then buffers stdin bytes in a first-word-fall-through FIFO.
module uart_boot_loader #(
    parameter int          IMEM_ADDR_W = 14,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'h99,
    parameter logic [7:0]  READY_BYTE  = 8'hAA
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_rdata,
    input  logic                   rx_rdata_ready,
    input  logic                   rx_ferr,
    output logic [7:0]             tx_sdata,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   boot_done,
    output logic [7:0]             stdin_rdata,
    output logic                   stdin_valid,
    input  logic                   stdin_pop,
    output logic                   err
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [32:0] CAPACITY = 33'd4 << IMEM_ADDR_W;

    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_SIZE  = 3'd1;
    localparam logic [2:0] S_PROG  = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    logic [2:0]  state;
    logic        tx_guard;
    logic [1:0]  size_idx;
    logic [31:0] size;
    logic [31:0] count;
    logic [31:0] word_buf;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    logic        rx_ok;
    logic        can_send;
    logic [31:0] size_next;
    logic [31:0] count_next;
    logic [1:0]  lane;
    logic [31:0] word_next;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;

    assign rx_ok      = rx_rdata_ready && !rx_ferr;
    // UART_TX reports busy one cycle late; the guard covers that gap.
    assign can_send   = !tx_busy && !tx_guard;
    assign size_next  = {rx_rdata, size[31:8]};
    assign count_next = count + 32'd1;
    assign lane       = count[1:0];
    assign word_next  = (lane == 2'd0) ? {24'd0, rx_rdata}
                                       : (word_buf | ({24'd0, rx_rdata} << {lane, 3'b000}));

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop         = stdin_pop && !fifo_empty;
    assign push        = (state == S_RUN) && rx_ok && (!fifo_full || pop);
    assign stdin_valid = !fifo_empty;
    assign stdin_rdata = fifo_empty ? 8'd0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= rx_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_SYNC;
            tx_guard   <= 1'b0;
            tx_start   <= 1'b0;
            tx_sdata   <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            boot_done  <= 1'b0;
            err        <= 1'b0;
            size_idx   <= 2'd0;
            size       <= 32'd0;
            count      <= 32'd0;
            word_buf   <= 32'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            tx_start <= 1'b0;
            tx_guard <= 1'b0;
            imem_we  <= 1'b0;
            if (rx_rdata_ready && rx_ferr) err <= 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if ((state == S_RUN) && rx_ok && fifo_full && !pop) err <= 1'b1;

            case (state)
                S_SYNC: begin
                    if (tx_start) begin
                        state <= S_SIZE;
                    end else if (can_send) begin
                        tx_start <= 1'b1;
                        tx_sdata <= SYNC_BYTE;
                        tx_guard <= 1'b1;
                    end
                end
                S_SIZE: begin
                    if (rx_ok) begin
                        size     <= size_next;
                        size_idx <= size_idx + 2'd1;
                        if (size_idx == 2'd3) begin
                            count <= 32'd0;
                            state <= (size_next == 32'd0) ? S_READY : S_PROG;
                            if ({1'b0, size_next} > CAPACITY) err <= 1'b1;
                        end
                    end
                end
                S_PROG: begin
                    if (rx_ok) begin
                        word_buf <= word_next;
                        count    <= count_next;
                        // Full word, or the zero-padded tail of the image; nothing past capacity.
                        if (((lane == 2'd3) || (count_next == size)) && ({1'b0, count} < CAPACITY)) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= count[IMEM_ADDR_W+1:2];
                            imem_wdata <= word_next;
                        end
                        if (count_next == size) state <= S_READY;
                    end
                end
                S_READY: begin
                    if (tx_start) begin
                        state     <= S_RUN;
                        boot_done <= 1'b1;
                    end else if (can_send) begin
                        tx_start <= 1'b1;
                        tx_sdata <= READY_BYTE;
                        tx_guard <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: randomized byte traffic against a queue-based protocol model.
module tb_uart_boot_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CAP   = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_rdata = 8'd0;
    logic          rx_rdata_ready = 1'b0;
    logic          rx_ferr = 1'b0;
    logic [7:0]    tx_sdata;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          boot_done;
    logic [7:0]    stdin_rdata;
    logic          stdin_valid;
    logic          stdin_pop = 1'b0;
    logic          err;

    uart_boot_loader #(.IMEM_ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
        .rx_ferr(rx_ferr), .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .boot_done(boot_done),
        .stdin_rdata(stdin_rdata), .stdin_valid(stdin_valid), .stdin_pop(stdin_pop), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_fifo[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  prog[$];
    bit          exp_err, exp_boot, pend_err;
    int          tx_seen;
    bit          prev_ok, prev_busy, prev_start;
    logic [7:0]  prev_sdata;
    int          busy_cnt;
    bit          busy_dly;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event with value 0x%0h, none expected", name, act);
    endtask

    // Per-cycle model: compare first, then apply this cycle's inputs to the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ok = 0; prev_busy = 0; prev_start = 0; prev_sdata = 8'd0;
            busy_cnt = 0; busy_dly = 0; tx_busy = 1'b0;
        end else begin
            bit do_pop, do_push;
            if (tx_start) begin
                tx_seen++;
                check("tx_start_when_idle", 32'({prev_busy, prev_start}), 32'd0);
                if (exp_tx.size() == 0) extra("tx_extra", 32'(tx_sdata));
                else check("tx_byte", 32'(tx_sdata), 32'(exp_tx.pop_front()));
            end
            if (prev_start && prev_sdata == 8'hAA) exp_boot = 1;
            check("boot_done", 32'(boot_done), 32'(exp_boot));
            if (imem_we) begin
                check("imem_we_latency", 32'(prev_ok), 32'd1);
                log_addr.push_back(32'(imem_addr));
                log_data.push_back(imem_wdata);
                if (exp_addr.size() == 0) extra("imem_extra", imem_wdata);
                else begin
                    check("imem_addr", 32'(imem_addr), exp_addr.pop_front());
                    check("imem_wdata", imem_wdata, exp_data.pop_front());
                end
            end
            check("stdin_valid", 32'(stdin_valid), 32'(exp_fifo.size() != 0));
            if (exp_fifo.size() != 0) check("stdin_rdata", 32'(stdin_rdata), 32'(exp_fifo[0]));
            check("err", 32'(err), 32'(exp_err));

            if (rx_rdata_ready && rx_ferr) exp_err = 1;
            if (pend_err) begin exp_err = 1; pend_err = 0; end
            do_pop  = stdin_pop && (exp_fifo.size() != 0);
            do_push = exp_boot && rx_rdata_ready && !rx_ferr;
            if (do_pop) void'(exp_fifo.pop_front());
            if (do_push) begin
                if (exp_fifo.size() < DEPTH) exp_fifo.push_back(rx_rdata);
                else exp_err = 1;
            end

            // UART_TX model: busy asserts one cycle late and lasts 10 cycles.
            if (busy_dly) begin busy_cnt = 10; busy_dly = 0; end
            else if (busy_cnt > 0) busy_cnt--;
            if (tx_start) busy_dly = 1;
            tx_busy = (busy_cnt > 0);

            prev_ok    = rx_rdata_ready && !rx_ferr;
            prev_busy  = tx_busy;
            prev_start = tx_start;
            prev_sdata = tx_sdata;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"},    32'(tx_start), 32'd0);
        check({tag, "_tx_sdata"},    32'(tx_sdata), 32'd0);
        check({tag, "_imem_we"},     32'(imem_we), 32'd0);
        check({tag, "_imem_addr"},   32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"},  imem_wdata, 32'd0);
        check({tag, "_boot_done"},   32'(boot_done), 32'd0);
        check({tag, "_stdin_valid"}, 32'(stdin_valid), 32'd0);
        check({tag, "_stdin_rdata"}, 32'(stdin_rdata), 32'd0);
        check({tag, "_err"},         32'(err), 32'd0);
    endtask

    task automatic do_reset(input bit check_now);
        reset_n = 1'b0;
        #1;
        if (check_now) check_zero("async_reset");
        rx_rdata_ready = 1'b0; rx_ferr = 1'b0; stdin_pop = 1'b0; rx_rdata = 8'd0;
        exp_tx.delete(); exp_addr.delete(); exp_data.delete(); exp_fifo.delete();
        log_addr.delete(); log_data.delete();
        exp_err = 0; exp_boot = 0; pend_err = 0; tx_seen = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        reset_n = 1'b1;
        exp_tx.push_back(8'h99);
        repeat (2) @(negedge clk);
        #1;
        check("sync_within_2", 32'(tx_seen), 32'd1);
        check("sync_byte", 32'(tx_sdata), 32'h99);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit f, input bit pe);
        @(posedge clk);
        #1;
        rx_rdata = b; rx_ferr = f; rx_rdata_ready = 1'b1;
        if (pe) pend_err = 1;
        @(posedge clk);
        #1;
        rx_rdata_ready = 1'b0; rx_ferr = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic boot(input logic [31:0] size, input int nsend, input bit ferr_in_size);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < nsend; i++) begin
            if (i % 4 == 0) w = 32'd0;
            w[(i % 4) * 8 +: 8] = prog[i];
            if (((i % 4 == 3) || (32'(i + 1) == size)) && i < CAP) begin
                exp_addr.push_back(32'(i / 4));
                exp_data.push_back(w);
            end
        end
        if (32'(nsend) == size) exp_tx.push_back(8'hAA);
        for (int k = 0; k < 4; k++) begin
            if (ferr_in_size && k == 2) send_byte(8'($urandom), 1'b1, 1'b0);
            send_byte(size[k*8 +: 8], 1'b0, (k == 3) && (size > 32'(CAP)));
        end
        for (int i = 0; i < nsend; i++) send_byte(prog[i], 1'b0, 1'b0);
        if (32'(nsend) == size) begin
            for (int c = 0; c < 100 && !boot_done; c++) @(negedge clk);
            #1;
            check("boot_done_reached", 32'(boot_done), 32'd1);
            check("ready_byte", 32'(tx_sdata), 32'hAA);
            check("writes_outstanding", 32'(exp_addr.size()), 32'd0);
            check("tx_outstanding", 32'(exp_tx.size()), 32'd0);
        end
    endtask

    task automatic run_traffic(input int cycles, input int pop_pct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            rx_rdata_ready = ($urandom_range(0, 99) < 40);
            rx_rdata       = 8'($urandom);
            rx_ferr        = rx_rdata_ready && ($urandom_range(0, 49) == 0);
            stdin_pop      = ($urandom_range(0, 99) < pop_pct);
        end
        @(posedge clk);
        #1;
        rx_rdata_ready = 1'b0; rx_ferr = 1'b0; stdin_pop = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] maxa;

        do_reset(1'b0);
        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        boot(32'd8, 8, 1'b0);
        check("t8_nwrites", 32'(log_data.size()), 32'd2);
        if (log_data.size() >= 2) begin
            check("t8_addr0", log_addr[0], 32'd0);
            check("t8_data0", log_data[0], 32'h44332211);
            check("t8_addr1", log_addr[1], 32'd1);
            check("t8_data1", log_data[1], 32'h88776655);
        end
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_head", 32'(stdin_rdata), 32'h00);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 stdin_pop = 1'b1;
            @(negedge clk);
            #1 check("pop_data", 32'(stdin_rdata), 32'(i));
        end
        @(posedge clk);
        #1 stdin_pop = 1'b0;
        @(negedge clk);
        #1 check("drained_valid", 32'(stdin_valid), 32'd0);

        do_reset(1'b1);
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        boot(32'd6, 6, 1'b0);
        check("t6_nwrites", 32'(log_data.size()), 32'd2);
        if (log_data.size() >= 2) begin
            check("t6_data0", log_data[0], 32'h04030201);
            check("t6_addr1", log_addr[1], 32'd1);
            check("t6_data1", log_data[1], 32'h00000605);
        end

        do_reset(1'b0);
        prog.delete();
        boot(32'd0, 0, 1'b0);
        check("t0_nwrites", 32'(log_data.size()), 32'd0);

        do_reset(1'b0);
        n = $urandom_range(1, 40);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
        boot(32'(n), n, 1'b1);
        check("ferr_size_err", 32'(err), 32'd1);
        run_traffic(300, 50);
        run_traffic(300, 10);

        do_reset(1'b0);
        prog.delete();
        for (int i = 0; i < 72; i++) prog.push_back(8'($urandom));
        boot(32'h00100000, 72, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("oversize_err", 32'(err), 32'd1);
        check("oversize_nwrites", 32'(log_addr.size()), 32'd16);
        maxa = 32'd0;
        foreach (log_addr[i]) if (log_addr[i] > maxa) maxa = log_addr[i];
        check("oversize_max_addr_le15", 32'(maxa <= 32'd15), 32'd1);

        do_reset(1'b0);
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
        boot(32'd8, 3, 1'b0);
        do_reset(1'b1);
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(8'($urandom));
        boot(32'd5, 5, 1'b0);
        check("restart_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 1) check("restart_addr0", log_addr[0], 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
